// File: rtl/dcache_dm.sv
// Blocking direct-mapped L1 data cache: write-through, no-write-allocate,
// whole-line refill over a word-granular memory port.
module dcache_dm #(
  parameter int NUM_LINES  = 64,
  parameter int LINE_WORDS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] dcache_addr,
  input  logic [31:0] dcache_wdata,
  input  logic        dcache_re,
  input  logic        dcache_we,
  output logic [31:0] dcache_rdata,
  output logic        dcache_hit,
  input  logic        flush,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata
);

  localparam int IB = $clog2(NUM_LINES);
  localparam int WB = $clog2(LINE_WORDS);
  localparam int CW = (WB > 0) ? WB : 1;
  localparam int TW = 30 - IB - WB;
  localparam int DI = IB + WB;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_REFILL = 2'd1;
  localparam logic [1:0] S_WRITE  = 2'd2;

  localparam logic [29:0] OFFSET_MASK = 30'(LINE_WORDS - 1);

  logic [1:0]           state;
  logic [NUM_LINES-1:0] valid;
  logic [TW-1:0]        tag_mem  [NUM_LINES];
  logic [31:0]          data_mem [NUM_LINES*LINE_WORDS];
  logic [29:0]          req_waddr;
  logic [31:0]          req_wdata;
  logic [CW-1:0]        count;

  logic [29:0]          look_waddr;
  logic                 look_hit;
  logic                 last_beat;
  logic [29:0]          refill_waddr;
  logic                 unused_bits;

  // All array addressing works on the 30-bit word address, so that a
  // single-word line (no offset field) needs no special casing.
  function automatic logic [IB-1:0] index_of(input logic [29:0] waddr);
    return IB'(waddr >> WB);
  endfunction

  function automatic logic [TW-1:0] tag_of(input logic [29:0] waddr);
    return TW'(waddr >> (WB + IB));
  endfunction

  function automatic logic [DI-1:0] slot_of(input logic [29:0] waddr);
    return DI'(waddr);
  endfunction

  assign unused_bits  = ^dcache_addr[1:0];
  assign look_waddr   = (state == S_WRITE) ? req_waddr : dcache_addr[31:2];
  assign look_hit     = valid[index_of(look_waddr)] &&
                        (tag_mem[index_of(look_waddr)] == tag_of(look_waddr));
  assign last_beat    = (count == CW'(LINE_WORDS - 1));
  assign refill_waddr = req_waddr | 30'(count);

  always_comb begin
    dcache_hit   = 1'b0;
    dcache_rdata = '0;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    if (!rst) begin
      case (state)
        S_IDLE: begin
          if (!dcache_we && dcache_re && look_hit) begin
            dcache_hit   = 1'b1;
            dcache_rdata = data_mem[slot_of(look_waddr)];
          end
        end
        S_REFILL: begin
          mem_req  = 1'b1;
          mem_addr = {refill_waddr, 2'b00};
        end
        S_WRITE: begin
          mem_req    = 1'b1;
          mem_we     = 1'b1;
          mem_addr   = {req_waddr, 2'b00};
          mem_wdata  = req_wdata;
          dcache_hit = mem_ready;
        end
        default: ;
      endcase
    end
  end

  // A miss invalidates its line up front, so an aborted refill can never
  // leave a half-filled line marked valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      valid     <= '0;
      count     <= '0;
      req_waddr <= '0;
      req_wdata <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (dcache_we) begin
            req_waddr <= dcache_addr[31:2];
            req_wdata <= dcache_wdata;
            state     <= S_WRITE;
          end else if (dcache_re && !look_hit) begin
            req_waddr <= dcache_addr[31:2] & ~OFFSET_MASK;
            count     <= '0;
            valid[index_of(dcache_addr[31:2])] <= 1'b0;
            state     <= S_REFILL;
          end
        end
        S_REFILL: begin
          if (flush) begin
            count <= '0;
            state <= S_IDLE;
          end else if (mem_ready) begin
            count <= count + CW'(1);
            if (last_beat) begin
              count <= '0;
              valid[index_of(req_waddr)] <= 1'b1;
              state <= S_IDLE;
            end
          end
        end
        S_WRITE: begin
          if (mem_ready) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == S_REFILL && !flush && mem_ready) begin
        data_mem[slot_of(refill_waddr)] <= mem_rdata;
        if (last_beat) begin
          tag_mem[index_of(req_waddr)] <= tag_of(req_waddr);
        end
      end
      if (state == S_WRITE && mem_ready && look_hit) begin
        data_mem[slot_of(req_waddr)] <= req_wdata;
      end
    end
  end

endmodule

// File: tb/tb_dcache_dm.sv
// Directed bench for dcache_dm: a line-level cache model checks every cycle,
// and literal expectations pin the scenario results.
module tb_dcache_dm;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] dcache_addr = '0;
  logic [31:0] dcache_wdata = '0;
  logic        dcache_re = 1'b0;
  logic        dcache_we = 1'b0;
  logic [31:0] dcache_rdata;
  logic        dcache_hit;
  logic        flush = 1'b0;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_rdata = '0;

  int checks = 0;
  int errors = 0;

  // Cache model: per-index resident line number and per-word data.
  localparam int MD_IDLE   = 0;
  localparam int MD_REFILL = 1;
  localparam int MD_WRITE  = 2;

  bit          m_valid [64];
  logic [31:0] m_line  [64];
  logic [31:0] m_data  [256];
  int          m_mode  = MD_IDLE;
  int          m_beats = 0;
  logic [31:0] m_addr  = '0;
  logic [31:0] m_wdata = '0;

  logic        s_hit, s_req, s_we;
  logic [31:0] s_rdata, s_addr, s_wdata;
  logic [31:0] addr_q[$];

  dcache_dm dut (
    .clk(clk), .rst(rst),
    .dcache_addr(dcache_addr), .dcache_wdata(dcache_wdata),
    .dcache_re(dcache_re), .dcache_we(dcache_we),
    .dcache_rdata(dcache_rdata), .dcache_hit(dcache_hit),
    .flush(flush),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  function automatic bit m_hit(input logic [31:0] a);
    return m_valid[(a >> 4) & 63] && (m_line[(a >> 4) & 63] == (a >> 4));
  endfunction

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Expected outputs follow from the model's current activity and inputs.
  task automatic checkOutput();
    logic        e_hit, e_req, e_we;
    logic [31:0] e_rdata, e_addr, e_wdata;
    e_hit = 0; e_req = 0; e_we = 0; e_rdata = 0; e_addr = 0; e_wdata = 0;
    if (!rst) begin
      if (m_mode == MD_IDLE) begin
        if (!dcache_we && dcache_re && m_hit(dcache_addr)) begin
          e_hit   = 1;
          e_rdata = m_data[(dcache_addr >> 2) & 255];
        end
      end else if (m_mode == MD_REFILL) begin
        e_req  = 1;
        e_addr = m_addr + 32'(4 * m_beats);
      end else begin
        e_req   = 1;
        e_we    = 1;
        e_addr  = m_addr;
        e_wdata = m_wdata;
        e_hit   = mem_ready;
      end
    end
    cmp("cyc_hit", s_hit, e_hit);
    cmp("cyc_rdata", s_rdata, e_rdata);
    cmp("cyc_mem_req", s_req, e_req);
    cmp("cyc_mem_we", s_we, e_we);
    cmp("cyc_mem_addr", s_addr, e_addr);
    cmp("cyc_mem_wdata", s_wdata, e_wdata);
  endtask

  task automatic modelUpdate();
    if (rst) begin
      foreach (m_valid[i]) m_valid[i] = 0;
      m_mode  = MD_IDLE;
      m_beats = 0;
    end else if (m_mode == MD_IDLE) begin
      if (dcache_we) begin
        m_mode  = MD_WRITE;
        m_addr  = dcache_addr & ~32'h3;
        m_wdata = dcache_wdata;
      end else if (dcache_re && !m_hit(dcache_addr)) begin
        m_valid[(dcache_addr >> 4) & 63] = 0;
        m_mode  = MD_REFILL;
        m_addr  = dcache_addr & ~32'hF;
        m_beats = 0;
      end
    end else if (m_mode == MD_REFILL) begin
      if (flush) begin
        m_mode = MD_IDLE;
      end else if (mem_ready) begin
        m_data[((m_addr >> 2) + 32'(m_beats)) & 255] = mem_rdata;
        m_beats++;
        if (m_beats == 4) begin
          m_valid[(m_addr >> 4) & 63] = 1;
          m_line[(m_addr >> 4) & 63]  = m_addr >> 4;
          m_mode = MD_IDLE;
        end
      end
    end else if (mem_ready) begin
      if (m_hit(m_addr)) m_data[(m_addr >> 2) & 255] = m_wdata;
      m_mode = MD_IDLE;
    end
  endtask

  // One clock cycle: drive at negedge, sample and check, then advance model.
  task automatic applyStimulus(input logic r, input logic re, input logic we,
                               input logic [31:0] a, input logic [31:0] wd,
                               input logic fl, input logic rdy, input logic [31:0] rd);
    @(negedge clk);
    rst = r; dcache_re = re; dcache_we = we; dcache_addr = a; dcache_wdata = wd;
    flush = fl; mem_ready = rdy; mem_rdata = rd;
    #1;
    s_hit = dcache_hit; s_rdata = dcache_rdata; s_req = mem_req;
    s_we = mem_we; s_addr = mem_addr; s_wdata = mem_wdata;
    checkOutput();
    modelUpdate();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // abort: 0 none, 1 flush after abort_beat beats, 2 reset after abort_beat beats.
  task automatic runLoad(input logic [31:0] a, input logic [31:0] base, input bit stall,
                         input int abort, input int abort_beat, output int n);
    bit done = 0;
    addr_q.delete();
    n = -1;
    for (int c = 0; c < 30 && !done; c++) begin
      logic rdy;
      bit   ab;
      rdy = !(stall && (c % 3 == 2));
      ab  = (abort != 0) && (m_mode == MD_REFILL) && (m_beats == abort_beat);
      applyStimulus((ab && abort == 2) ? 1'b1 : 1'b0, 1, 0, a, 0,
                    (ab && abort == 1) ? 1'b1 : 1'b0, rdy, base + 32'(m_beats));
      if (s_req && !s_we && rdy) addr_q.push_back(s_addr);
      if (ab) begin
        done = 1;
      end else if (s_hit) begin
        n = c;
        done = 1;
      end
    end
    if (!done) cmp("load_timeout", 32'd0, 32'd1);
  endtask

  task automatic runStore(input logic [31:0] a, input logic [31:0] d, input bit stall,
                          input logic fl, output int n);
    n = -1;
    for (int c = 0; c < 20 && n < 0; c++) begin
      applyStimulus(0, 0, 1, a, d, fl, !(stall && c == 1), 0);
      if (s_hit) n = c;
    end
    if (n < 0) cmp("store_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int n;
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 1, 0, 32'h100, 0, 0, 1, 0);
    idle(1);
    cmp("rst_mem_req", 32'(s_req), 0);
    cmp("rst_hit", 32'(s_hit), 0);

    runLoad(32'h100, 32'hA0, 0, 0, 0, n);
    cmp("t1_latency", n, 5);
    cmp("t1_rdata", s_rdata, 32'hA0);
    cmp("t1_beats", addr_q.size(), 4);
    for (int i = 0; i < 4 && i < addr_q.size(); i++)
      cmp("t1_beat_addr", addr_q[i], 32'h100 + 32'(4 * i));
    idle(1);

    runLoad(32'h108, 0, 0, 0, 0, n);
    cmp("t2_latency", n, 0);
    cmp("t2_rdata", s_rdata, 32'hA2);
    cmp("t2_mem_req", 32'(s_req), 0);

    runStore(32'h104, 32'hDEAD_BEEF, 0, 0, n);
    cmp("t3_latency", n, 1);
    cmp("t3_mem_addr", s_addr, 32'h104);
    cmp("t3_mem_wdata", s_wdata, 32'hDEAD_BEEF);
    runLoad(32'h104, 0, 0, 0, 0, n);
    cmp("t3_reload_lat", n, 0);
    cmp("t3_reload_data", s_rdata, 32'hDEAD_BEEF);

    runStore(32'h2000, 32'h1234, 0, 0, n);
    cmp("t4_mem_addr", s_addr, 32'h2000);
    runLoad(32'h2000, 32'hB0, 1, 0, 0, n);
    cmp("t4_refill_beats", addr_q.size(), 4);
    cmp("t4_rdata", s_rdata, 32'hB0);

    runStore(32'h2004, 32'h55, 1, 1, n);
    cmp("wr_flush_latency", n, 2);
    runLoad(32'h2004, 0, 0, 0, 0, n);
    cmp("wr_flush_data", s_rdata, 32'h55);

    applyStimulus(0, 1, 0, 32'h108, 0, 1, 0, 0);
    cmp("idle_flush_hit", 32'(s_hit), 1);
    cmp("idle_flush_rdata", s_rdata, 32'hA2);

    runLoad(32'h4100, 32'hE0, 0, 1, 2, n);
    idle(1);
    cmp("t5_idle_req", 32'(s_req), 0);
    runLoad(32'h100, 32'hC0, 0, 0, 0, n);
    cmp("t5_reload_lat", n, 5);
    cmp("t5_rdata", s_rdata, 32'hC0);

    runLoad(32'h4100, 32'hE0, 0, 2, 2, n);
    idle(1);
    cmp("t6_idle_req", 32'(s_req), 0);
    runLoad(32'h108, 32'hF0, 0, 0, 0, n);
    cmp("t6_reload_lat", n, 5);
    cmp("t6_rdata", s_rdata, 32'hF2);
    runLoad(32'h2000, 32'h70, 0, 0, 0, n);
    cmp("t6_other_line_lat", n, 5);
    cmp("t6_other_rdata", s_rdata, 32'h70);
    idle(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
